// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
//   Shares one external divider among REQ_NUM requesters. Requests are
//   arbitrated round-robin in IDLE. The winner's operands are latched, and
//   the divider's en/done handshake is sequenced. The result is returned on a
//   shared bus with a one-cycle one-hot resp_valid pulse. A zero divisor is
//   answered locally and never reaches the divider.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req               per-requester request, held until ack
//   req_sign          per-requester signed flag
//   req_dividend      flattened dividends, requester i at [i*DATA_BITS +: DATA_BITS]
//   req_divisor       flattened divisors, same packing
//   ack               one-hot 1-cycle pulse: request accepted, operands captured
//   resp_valid        one-hot 1-cycle pulse: result on resp_* is for that requester
//   resp_quotient     shared result bus (held until next capture)
//   resp_remainder    shared result bus (held until next capture)
//   resp_dz           divide-by-zero flag, qualified by resp_valid
//   busy              high in every state except IDLE
//   div_en            start strobe to the divider
//   div_sign          signed mode to the divider
//   div_dividend      dividend to the divider
//   div_divisor       divisor to the divider
//   div_done          completion strobe from the divider
//   div_quotient      quotient from the divider
//   div_remainder     remainder from the divider
// ---------------------------------------------------------------------------
module div_arbiter #(
  parameter int DATA_BITS = 32,
  parameter int REQ_NUM   = 4,
  parameter int REQ_BITS  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_NUM-1:0]           req,
  input  logic [REQ_NUM-1:0]           req_sign,
  input  logic [REQ_NUM*DATA_BITS-1:0] req_dividend,
  input  logic [REQ_NUM*DATA_BITS-1:0] req_divisor,
  output logic [REQ_NUM-1:0]           ack,
  output logic [REQ_NUM-1:0]           resp_valid,
  output logic [DATA_BITS-1:0]         resp_quotient,
  output logic [DATA_BITS-1:0]         resp_remainder,
  output logic                         resp_dz,
  output logic                         busy,
  output logic                         div_en,
  output logic                         div_sign,
  output logic [DATA_BITS-1:0]         div_dividend,
  output logic [DATA_BITS-1:0]         div_divisor,
  input  logic                         div_done,
  input  logic [DATA_BITS-1:0]         div_quotient,
  input  logic [DATA_BITS-1:0]         div_remainder
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state;
  logic [REQ_BITS-1:0]  grant;
  logic [REQ_BITS-1:0]  last_grant;
  logic [REQ_BITS-1:0]  winner;
  logic                 hit;
  logic                 sign_q;
  logic [DATA_BITS-1:0] dividend_q;
  logic [DATA_BITS-1:0] divisor_q;

  // Round-robin search starting one past the previous grant, wrapping modulo
  // REQ_NUM. The first asserted request found wins.
  always_comb begin
    winner = '0;
    hit    = 1'b0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      if (!hit && req[(int'(last_grant) + k) % REQ_NUM]) begin
        winner = REQ_BITS'((int'(last_grant) + k) % REQ_NUM);
        hit    = 1'b1;
      end
    end
  end

  // Main sequencer. ack and resp_valid are cleared every cycle and set only
  // on the transition into ISSUE or RESP. This makes each a single-cycle
  // pulse that can never overlap the other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      grant          <= '0;
      last_grant     <= REQ_BITS'(REQ_NUM - 1);
      sign_q         <= 1'b0;
      dividend_q     <= '0;
      divisor_q      <= '0;
      ack            <= '0;
      resp_valid     <= '0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_dz        <= 1'b0;
    end else begin
      ack        <= '0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= winner;
            sign_q      <= req_sign[winner];
            dividend_q  <= req_dividend[int'(winner)*DATA_BITS +: DATA_BITS];
            divisor_q   <= req_divisor[int'(winner)*DATA_BITS +: DATA_BITS];
            ack[winner] <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (divisor_q != '0) begin
            state <= WAIT;
          end else begin
            // Zero divisor: all-ones quotient, dividend passed through raw.
            resp_quotient     <= '1;
            resp_remainder    <= dividend_q;
            resp_dz           <= 1'b1;
            resp_valid[grant] <= 1'b1;
            state             <= RESP;
          end
        end
        WAIT: begin
          if (div_done) begin
            resp_quotient     <= div_quotient;
            resp_remainder    <= div_remainder;
            resp_dz           <= 1'b0;
            resp_valid[grant] <= 1'b1;
            state             <= RESP;
          end
        end
        RESP: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The divider is started only by the single ISSUE cycle. Its operands come
  // straight from the latched registers, so they stay stable through WAIT.
  assign busy         = (state != IDLE);
  assign div_en       = (state == ISSUE) && (divisor_q != '0);
  assign div_sign     = sign_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_arbiter
//   Self-checking bench for div_arbiter with a behavioural DATA_BITS-cycle
//   divider attached. Each scenario task drives directed vectors and compares
//   the observations against hand-computed values.
// ---------------------------------------------------------------------------
module tb_div_arbiter;
  localparam int DATA_BITS = 32;
  localparam int REQ_NUM   = 4;
  localparam int REQ_BITS  = 2;

  logic                         clk;
  logic                         rst;
  logic [REQ_NUM-1:0]           req;
  logic [REQ_NUM-1:0]           req_sign;
  logic [REQ_NUM*DATA_BITS-1:0] req_dividend;
  logic [REQ_NUM*DATA_BITS-1:0] req_divisor;
  logic [REQ_NUM-1:0]           ack;
  logic [REQ_NUM-1:0]           resp_valid;
  logic [DATA_BITS-1:0]         resp_quotient;
  logic [DATA_BITS-1:0]         resp_remainder;
  logic                         resp_dz;
  logic                         busy;
  logic                         div_en;
  logic                         div_sign;
  logic [DATA_BITS-1:0]         div_dividend;
  logic [DATA_BITS-1:0]         div_divisor;
  logic                         div_done;
  logic [DATA_BITS-1:0]         div_quotient;
  logic [DATA_BITS-1:0]         div_remainder;

  int checks = 0;
  int fails  = 0;

  div_arbiter #(.DATA_BITS(DATA_BITS), .REQ_NUM(REQ_NUM), .REQ_BITS(REQ_BITS)) dut (
    .clk(clk), .rst(rst), .req(req), .req_sign(req_sign),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .ack(ack), .resp_valid(resp_valid), .resp_quotient(resp_quotient),
    .resp_remainder(resp_remainder), .resp_dz(resp_dz), .busy(busy),
    .div_en(div_en), .div_sign(div_sign), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural divider: en captured at an edge, DATA_BITS calc cycles, then
  // a one-cycle done. It shares rst with the arbiter.
  logic                 m_busy;
  int                   m_cnt;
  logic                 m_done;
  logic                 done_force;
  logic [DATA_BITS-1:0] m_q, m_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end else if (div_en) begin
        m_busy <= 1'b1;
        m_cnt  <= DATA_BITS;
        if (div_divisor == '0) begin
          m_q <= '1;
          m_r <= div_dividend;
        end else if (div_sign) begin
          m_q <= $signed(div_dividend) / $signed(div_divisor);
          m_r <= $signed(div_dividend) % $signed(div_divisor);
        end else begin
          m_q <= div_dividend / div_divisor;
          m_r <= div_dividend % div_divisor;
        end
      end
    end
  end

  assign div_done      = m_done | done_force;
  assign div_quotient  = m_q;
  assign div_remainder = m_r;

  // Observations filled by run_one / run_multi.
  int                   o_ack_cyc, o_en_first, o_en_cnt, o_busy_cnt, o_resp_cyc;
  logic [REQ_NUM-1:0]   o_ack_vec, o_resp_vec;
  logic [DATA_BITS-1:0] o_q, o_r;
  logic                 o_dz, o_busy_after;
  int                   rr_order[4];
  logic [DATA_BITS-1:0] rr_q[4];
  logic [DATA_BITS-1:0] rr_r[4];
  int                   rr_nack, rr_nresp, rr_gap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [REQ_NUM-1:0] v);
    for (int i = 0; i < REQ_NUM; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_ops(input int idx, input logic s, input logic [DATA_BITS-1:0] a,
                         input logic [DATA_BITS-1:0] b);
    req_sign[idx]                       = s;
    req_dividend[idx*DATA_BITS +: DATA_BITS] = a;
    req_divisor[idx*DATA_BITS +: DATA_BITS]  = b;
  endtask

  // One request raised in cycle 0, dropped as soon as ack is seen.
  task automatic run_one(input int idx, input logic s, input logic [DATA_BITS-1:0] a,
                         input logic [DATA_BITS-1:0] b);
    o_ack_cyc = -1; o_en_first = -1; o_en_cnt = 0; o_busy_cnt = 0; o_resp_cyc = -1;
    o_ack_vec = '0; o_resp_vec = '0; o_q = '0; o_r = '0; o_dz = 1'b0; o_busy_after = 1'b1;
    set_ops(idx, s, a, b);
    req[idx] = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (ack != '0 && o_ack_cyc < 0) begin
        o_ack_cyc = c; o_ack_vec = ack; req[idx] = 1'b0;
      end
      if (div_en) begin
        o_en_cnt++;
        if (o_en_first < 0) o_en_first = c;
      end
      if (busy) o_busy_cnt++;
      if (resp_valid != '0) begin
        o_resp_cyc = c; o_resp_vec = resp_valid;
        o_q = resp_quotient; o_r = resp_remainder; o_dz = resp_dz;
        break;
      end
    end
    req[idx] = 1'b0;
    if (o_resp_cyc > 0) begin
      tick();
      o_busy_after = busy;
    end
  endtask

  // Several simultaneous requests; each dropped on its own ack.
  task automatic run_multi(input logic [REQ_NUM-1:0] mask);
    int last_resp;
    int want;
    want = $countones(mask);
    rr_nack = 0; rr_nresp = 0; rr_gap = -1; last_resp = -1;
    for (int i = 0; i < 4; i++) begin
      rr_order[i] = -1; rr_q[i] = '0; rr_r[i] = '0;
    end
    req = mask;
    for (int c = 1; c <= 400 && rr_nresp < want; c++) begin
      tick();
      if (ack != '0) begin
        if (rr_nack < 4) rr_order[rr_nack] = onehot_idx(ack);
        rr_nack++;
        req = req & ~ack;
      end
      if (div_en && last_resp >= 0 && rr_gap < 0) rr_gap = c - last_resp;
      if (resp_valid != '0 && onehot_idx(resp_valid) >= 0) begin
        rr_q[onehot_idx(resp_valid)] = resp_quotient;
        rr_r[onehot_idx(resp_valid)] = resp_remainder;
        rr_nresp++;
        last_resp = c;
      end
    end
    req = '0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (ack !== 4'b0) begin fails++; $display("[TB] FAIL reset_ack: got %b want 0000", ack); end
    checks++; if (resp_valid !== 4'b0) begin fails++; $display("[TB] FAIL reset_resp_valid: got %b want 0000", resp_valid); end
    checks++; if (busy !== 1'b0 || div_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy_en: got %b%b want 00", busy, div_en); end
    checks++; if (resp_quotient !== 32'h0 || resp_remainder !== 32'h0 || resp_dz !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_resp_bus: got %h %h %b want 0 0 0", resp_quotient, resp_remainder, resp_dz); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    run_one(2, 1'b0, 32'd100, 32'd7);
    checks++; if (o_ack_cyc !== 1 || o_ack_vec !== 4'b0100) begin fails++; $display("[TB] FAIL unsigned_ack: got cyc %0d vec %b want 1 0100", o_ack_cyc, o_ack_vec); end
    checks++; if (o_en_first !== 1 || o_en_cnt !== 1) begin fails++; $display("[TB] FAIL unsigned_en: got first %0d count %0d want 1 1", o_en_first, o_en_cnt); end
    checks++; if (o_resp_cyc !== 35 || o_resp_vec !== 4'b0100) begin fails++; $display("[TB] FAIL unsigned_latency: got cyc %0d vec %b want 35 0100", o_resp_cyc, o_resp_vec); end
    checks++; if (o_q !== 32'd14 || o_r !== 32'd2 || o_dz !== 1'b0) begin fails++; $display("[TB] FAIL unsigned_result: got q %0d r %0d dz %b want 14 2 0", o_q, o_r, o_dz); end
    checks++; if (o_busy_cnt !== 35 || o_busy_after !== 1'b0) begin fails++; $display("[TB] FAIL unsigned_busy: got %0d cycles after %b want 35 0", o_busy_cnt, o_busy_after); end
  endtask

  task automatic test_signed();
    run_one(0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    checks++; if (o_resp_cyc !== 35 || o_resp_vec !== 4'b0001) begin fails++; $display("[TB] FAIL signed_latency: got cyc %0d vec %b want 35 0001", o_resp_cyc, o_resp_vec); end
    checks++; if (o_q !== 32'hFFFF_FFFD || o_r !== 32'hFFFF_FFFF || o_dz !== 1'b0) begin fails++; $display("[TB] FAIL signed_result: got q %h r %h dz %b want fffffffd ffffffff 0", o_q, o_r, o_dz); end
  endtask

  task automatic test_div_zero();
    run_one(1, 1'b0, 32'h0000_1234, 32'd0);
    checks++; if (o_ack_cyc !== 1 || o_ack_vec !== 4'b0010) begin fails++; $display("[TB] FAIL dz_ack: got cyc %0d vec %b want 1 0010", o_ack_cyc, o_ack_vec); end
    checks++; if (o_resp_cyc !== 2 || o_resp_vec !== 4'b0010) begin fails++; $display("[TB] FAIL dz_latency: got cyc %0d vec %b want 2 0010", o_resp_cyc, o_resp_vec); end
    checks++; if (o_q !== 32'hFFFF_FFFF || o_r !== 32'h0000_1234 || o_dz !== 1'b1) begin fails++; $display("[TB] FAIL dz_result: got q %h r %h dz %b want ffffffff 00001234 1", o_q, o_r, o_dz); end
    checks++; if (o_en_cnt !== 0) begin fails++; $display("[TB] FAIL dz_no_en: got %0d div_en cycles want 0", o_en_cnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 1'b0, 32'd100, 32'(i + 1));
    run_multi(4'b1111);
    checks++; if (rr_order[0] !== 0 || rr_order[1] !== 1 || rr_order[2] !== 2 || rr_order[3] !== 3) begin
      fails++; $display("[TB] FAIL rr_order_all: got %0d %0d %0d %0d want 0 1 2 3", rr_order[0], rr_order[1], rr_order[2], rr_order[3]); end
    checks++; if (rr_q[0] !== 32'd100 || rr_q[1] !== 32'd50 || rr_q[2] !== 32'd33 || rr_q[3] !== 32'd25) begin
      fails++; $display("[TB] FAIL rr_quotients: got %0d %0d %0d %0d want 100 50 33 25", rr_q[0], rr_q[1], rr_q[2], rr_q[3]); end
    checks++; if (rr_r[2] !== 32'd1) begin fails++; $display("[TB] FAIL rr_remainder2: got %0d want 1", rr_r[2]); end
    checks++; if (rr_gap !== 2) begin fails++; $display("[TB] FAIL back_to_back_gap: got %0d want 2", rr_gap); end
    run_one(1, 1'b0, 32'd9, 32'd0);
    set_ops(0, 1'b0, 32'd7, 32'd0);
    set_ops(3, 1'b0, 32'd8, 32'd0);
    run_multi(4'b1001);
    checks++; if (rr_nack !== 2 || rr_order[0] !== 3 || rr_order[1] !== 0) begin
      fails++; $display("[TB] FAIL rr_order_1001: got n %0d order %0d %0d want 2 3 0", rr_nack, rr_order[0], rr_order[1]); end
    checks++; if (rr_r[3] !== 32'd8 || rr_r[0] !== 32'd7) begin fails++; $display("[TB] FAIL rr_routing: got r3 %0d r0 %0d want 8 7", rr_r[3], rr_r[0]); end
  endtask

  task automatic test_reset_mid_wait();
    int late_resp;
    set_ops(2, 1'b0, 32'd100, 32'd7);
    req[2] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (ack[2]) req[2] = 1'b0;
    end
    checks++; if (busy !== 1'b1 || div_dividend !== 32'd100) begin fails++; $display("[TB] FAIL midwait_pre: got busy %b dividend %0d want 1 100", busy, div_dividend); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || div_en !== 1'b0 || ack !== 4'b0 || resp_valid !== 4'b0) begin
      fails++; $display("[TB] FAIL midwait_ctrl: got busy %b en %b ack %b rv %b want 0 0 0000 0000", busy, div_en, ack, resp_valid); end
    checks++; if (resp_quotient !== 32'h0 || resp_remainder !== 32'h0 || resp_dz !== 1'b0 || div_dividend !== 32'h0) begin
      fails++; $display("[TB] FAIL midwait_data: got q %h r %h dz %b dividend %h want all zero", resp_quotient, resp_remainder, resp_dz, div_dividend); end
    tick();
    rst = 1'b0;
    late_resp = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (resp_valid != '0) late_resp++;
    end
    checks++; if (late_resp !== 0) begin fails++; $display("[TB] FAIL midwait_no_resp: got %0d responses want 0", late_resp); end
    run_one(2, 1'b0, 32'd100, 32'd7);
    checks++; if (o_ack_cyc !== 1 || o_resp_cyc !== 35 || o_q !== 32'd14 || o_r !== 32'd2) begin
      fails++; $display("[TB] FAIL midwait_recover: got ack %0d resp %0d q %0d r %0d want 1 35 14 2", o_ack_cyc, o_resp_cyc, o_q, o_r); end
  endtask

  task automatic test_back_to_back();
    int acks[2];
    int resps[2];
    int na, nr;
    na = 0; nr = 0;
    acks[0] = -1; acks[1] = -1; resps[0] = -1; resps[1] = -1;
    set_ops(3, 1'b0, 32'd5, 32'd0);
    req[3] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ack[3]) begin
        if (na < 2) acks[na] = c;
        na++;
        if (na == 2) req[3] = 1'b0;
      end
      if (resp_valid[3]) begin
        if (nr < 2) resps[nr] = c;
        nr++;
      end
    end
    req[3] = 1'b0;
    checks++; if (na !== 2 || acks[0] !== 1 || acks[1] !== 4) begin fails++; $display("[TB] FAIL stale_acks: got n %0d at %0d %0d want 2 at 1 4", na, acks[0], acks[1]); end
    checks++; if (nr !== 2 || resps[0] !== 2 || resps[1] !== 5) begin fails++; $display("[TB] FAIL stale_resps: got n %0d at %0d %0d want 2 at 2 5", nr, resps[0], resps[1]); end
  endtask

  task automatic test_spurious_done();
    logic [DATA_BITS-1:0] r_before;
    int stray;
    r_before = resp_remainder;
    stray = 0;
    done_force = 1'b1;
    tick();
    done_force = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (resp_valid != '0 || busy) stray++;
      tick();
    end
    checks++; if (stray !== 0 || resp_remainder !== r_before) begin
      fails++; $display("[TB] FAIL idle_done_ignored: got %0d stray cycles r %h want 0 %h", stray, resp_remainder, r_before); end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_sign = '0; req_dividend = '0; req_divisor = '0; done_force = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_round_robin();
    test_reset_mid_wait();
    test_back_to_back();
    test_spurious_done();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "[TB] timeout");
  end
endmodule
